// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle for the multi-cycle HI/LO unit.
//
// Handshake: the requester drives start with op/a/b. The unit samples them
// only while it is idle (busy=0); a start seen while busy is dropped. There
// is no backpressure on results: done is a one-cycle pulse and hi/lo/dz are
// valid in that cycle. After done, hi/lo hold until the next accepted start.
//
// Signals: start, op[1:0], a, b  (requester -> unit)
//          busy, done, hi, lo, dz (unit -> requester)
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (output start, op, a, b, input busy, done, hi, lo, dz);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO unit for MULTU/MULT/DIVU/DIV.
// One ripple adder is time-shared by a fixed sequence of states:
//   IDLE -> PRE_A -> PRE_B -> ITER x WIDTH -> POST_LO -> POST_HI -> DONE -> IDLE
// giving a fixed latency of 37 cycles from the start sample to done.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, forces IDLE and clears state
//   bus        muldiv_if slave (start/op/a/b in; busy/done/hi/lo/dz out)
//   dbg_state  current FSM state encoding, for observation only
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  muldiv_if.slave    bus,
  output logic [2:0] dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_A, S_PRE_B, S_ITER, S_POST_LO, S_POST_HI, S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_reg, b_reg, m_reg, hi_r, lo_r;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt;
  logic             neg_p, neg_q, neg_r, c_r, dz_r;
  logic             busy_c, done_c;

  // Shared adder
  logic [WIDTH-1:0] add_a, add_b, y;
  logic             cin, cout;

  logic             is_div, is_signed, neg_a, neg_b;
  logic [WIDTH-1:0] rem_sh;

  assign is_div    = op_reg[1];
  assign is_signed = op_reg[0];
  assign neg_a     = is_signed & a_reg[WIDTH-1];
  assign neg_b     = is_signed & b_reg[WIDTH-1];
  // Partial remainder shifted left by one; the bit shifted out of hi is the
  // 33rd bit of the trial subtraction.
  assign rem_sh    = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // FSM next state and status outputs
  always_comb begin
    state_n = state;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_n = S_PRE_A;
      end
      S_PRE_A:   state_n = S_PRE_B;
      S_PRE_B:   state_n = S_ITER;
      S_ITER:    if (cnt == CW'(WIDTH - 1)) state_n = S_POST_LO;
      S_POST_LO: state_n = S_POST_HI;
      S_POST_HI: state_n = S_DONE;
      S_DONE: begin
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  // Adder operand selection, owned entirely by the current state
  always_comb begin
    add_a = '0;
    add_b = '0;
    cin   = 1'b0;
    case (state)
      S_PRE_A: begin
        add_a = neg_a ? ~a_reg : a_reg;
        cin   = neg_a;
      end
      S_PRE_B: begin
        add_a = neg_b ? ~b_reg : b_reg;
        cin   = neg_b;
      end
      S_ITER: begin
        if (is_div) begin
          add_a = rem_sh;
          add_b = ~m_reg;
          cin   = 1'b1;
        end else begin
          add_a = hi_r;
          add_b = lo_r[0] ? m_reg : '0;
        end
      end
      S_POST_LO: begin
        add_a = ~lo_r;
        cin   = 1'b1;
      end
      S_POST_HI: begin
        add_a = ~hi_r;
        // Mult negates the full 64-bit product, so hi takes lo's carry.
        cin   = is_div ? 1'b1 : c_r;
      end
      default: ;
    endcase
    {cout, y} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      op_reg <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      c_r    <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            op_reg <= bus.op;
            dz_r   <= bus.op[1] & (bus.b == '0);
          end
        end
        S_PRE_A: begin
          hi_r <= '0;
          if (is_div) lo_r  <= y;   // dividend
          else        m_reg <= y;   // multiplicand
        end
        S_PRE_B: begin
          if (is_div) m_reg <= y;   // divisor
          else        lo_r  <= y;   // multiplier
          neg_p <= is_signed & ~is_div & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          neg_q <= is_signed &  is_div & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          neg_r <= is_signed &  is_div &  a_reg[WIDTH-1];
          cnt   <= '0;
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            // Restoring step: subtract when the shifted remainder >= divisor,
            // either because it overflowed 32 bits or the subtraction carried.
            if (hi_r[WIDTH-1] | cout) begin
              hi_r <= y;
              lo_r <= {lo_r[WIDTH-2:0], 1'b1};
            end else begin
              hi_r <= rem_sh;
              lo_r <= {lo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi_r, lo_r} <= {cout, y, lo_r[WIDTH-1:1]};
          end
        end
        S_POST_LO: begin
          c_r <= cout;
          if (dz_r)                                   lo_r <= '1;
          else if ((~is_div & neg_p) | (is_div & neg_q)) lo_r <= y;
        end
        S_POST_HI: begin
          if (dz_r)                                   hi_r <= a_reg;
          else if ((~is_div & neg_p) | (is_div & neg_r)) hi_r <= y;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.dz    = dz_r;
  assign dbg_state = state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven and scoreboarded bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  logic [64:0] exp_q[$];   // {dz, hi, lo}

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, t;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = 0; sb = 0; t = 0; p = '0; q = '0; r = '0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      2'b01: begin
        sa = $signed(a);
        sb = $signed(b);
        t  = sa * sb;
        return {1'b0, 64'(t)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = a / b;
          r = a % b;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          t  = sa / sb;
          q  = t[31:0];
          t  = sa % sb;
          r  = t[31:0];
        end
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, required no done", bus.hi, bus.lo);
      end else begin
        check("result", {bus.dz, bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks. Both assume they are entered just after a falling edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [64:0] exp, input bit push);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One rising edge has already sampled start, so counting starts at 1.
  task automatic wait_done(input string name);
    int cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 65'(cyc), 65'(37));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp);
    @(negedge clk);
    start_op(op, a, b, exp, 1'b1);
    wait_done("latency");
    @(negedge clk);
  endtask

  initial begin
    int          cyc;
    int          busy_low;
    int          base;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[4]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
    vecs[11] = '{2'b00, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy",  65'(bus.busy),  65'(0));
    check("rst_done",  65'(bus.done),  65'(0));
    check("rst_hi",    65'(bus.hi),    65'(0));
    check("rst_lo",    65'(bus.lo),    65'(0));
    check("rst_dz",    65'(bus.dz),    65'(0));
    check("rst_state", 65'(dbg_state), 65'(0));

    // Directed vector table
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].hi, vecs[i].lo});

    // Results hold after done
    check("hold_hi", 65'(bus.hi), 65'(32'h0000_0000));
    check("hold_lo", 65'(bus.lo), 65'(32'hFFFF_FFFF));
    check("idle_busy", 65'(bus.busy), 65'(0));

    // Random operands against the model
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, model(rop, ra, rb));
    end

    // Starts while busy and in DONE are ignored; a start in the next IDLE is accepted
    @(negedge clk);
    base = done_cnt;
    start_op(2'b00, 32'd6, 32'd7, model(2'b00, 32'd6, 32'd7), 1'b1);
    cyc      = 1;
    busy_low = 0;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) busy_low++;
      if (cyc == 5 || cyc == 20) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ign_latency", 65'(cyc), 65'(37));
    check("busy_held", 65'(busy_low), 65'(0));
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd55;
    bus.b     = 32'd2;
    @(negedge clk);
    check("idle_after_done", 65'(bus.busy), 65'(0));
    bus.a = 32'd9;
    bus.b = 32'd9;
    exp_q.push_back(model(2'b00, 32'd9, 32'd9));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accept", 65'(bus.busy), 65'(1));
    wait_done("b2b_latency");
    repeat (3) @(negedge clk);
    check("done_count", 65'(done_cnt - base), 65'(2));

    // Reset in the middle of ITER (count 10) aborts without a done pulse
    @(negedge clk);
    base = done_cnt;
    start_op(2'b00, 32'd5, 32'd7, '0, 1'b0);
    repeat (12) @(negedge clk);
    check("abort_in_iter", 65'(dbg_state), 65'(3));
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  65'(bus.busy), 65'(0));
    check("abort_hilo",  65'({bus.hi, bus.lo}), 65'(0));
    check("abort_done",  65'(bus.done), 65'(0));
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_done", 65'(done_cnt - base), 65'(0));
    run_op(2'b00, 32'd3, 32'd4, {1'b0, 32'h0, 32'h0000_000C});

    repeat (3) @(negedge clk);
    check("queue_empty", 65'(exp_q.size()), 65'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
